telemetry_pkt: RTL and testbench

//  Parametrised periodic telemetry framer feeding the 8-bit UART transmitter (trmt/tx_data/tx_done).

---
 rtl/telemetry_pkt.sv | 137 +++++++++++++
 tb/tb_telemetry_pkt.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/telemetry_pkt.sv
// Periodic telemetry framer: delimiter, then each channel as hi/lo bytes, handed to UART_tx one byte at a time.
// Defining TELEM_CHKSUM_EN appends a two's-complement checksum byte over the payload.
module telemetry_pkt #(
  parameter int          NUM_CH = 3,
  parameter int          CH_W   = 12,
  parameter int          PERIOD = 1048576,
  parameter logic [15:0] DELIM  = 16'hAA55
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [NUM_CH*CH_W-1:0]   ch_data,
  input  logic                     tx_done,
  output logic                     trmt,
  output logic [7:0]               tx_data,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     ovr
);

  localparam int CNT_W = $clog2(PERIOD);
`ifdef TELEM_CHKSUM_EN
  localparam int NBYTES = 3 + 2*NUM_CH;
`else
  localparam int NBYTES = 2 + 2*NUM_CH;
`endif
  localparam int IDX_W = $clog2(NBYTES);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               tick;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   pay_idx;
  logic [CH_W-1:0]    snap [NUM_CH];
  logic [15:0]        word;
  logic [7:0]         cur_byte;
  logic               last;
  logic               start, load, advance, finish;
`ifdef TELEM_CHKSUM_EN
  logic [7:0]         sum;
`endif

  assign tick = en && (cnt == CNT_W'(PERIOD-1));
  assign last = (idx == IDX_W'(NBYTES-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (!en || tick) cnt <= '0;
    else                  cnt <= cnt + CNT_W'(1);
  end

  // Byte selection: pay_idx counts payload bytes; its LSB picks lo over hi within a channel.
  always_comb begin
    word     = '0;
    cur_byte = 8'h00;
    pay_idx  = idx - IDX_W'(2);
    for (int i = 0; i < NUM_CH; i++) begin
      if (pay_idx[IDX_W-1:1] == (IDX_W-1)'(i)) word[CH_W-1:0] = snap[i];
    end
    if (idx == IDX_W'(0))      cur_byte = DELIM[15:8];
    else if (idx == IDX_W'(1)) cur_byte = DELIM[7:0];
`ifdef TELEM_CHKSUM_EN
    else if (last)             cur_byte = ~sum + 8'd1;
`endif
    else                       cur_byte = pay_idx[0] ? word[7:0] : word[15:8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    load      = 1'b0;
    advance   = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE: if (tick) begin
        state_nxt = S_LOAD;
        start     = 1'b1;
      end
      S_LOAD: begin
        load      = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: if (tx_done) begin
        if (last) begin
          finish    = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          advance   = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Ticks arriving mid-frame are reported and dropped; the snapshot only moves on an accepted tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trmt       <= 1'b0;
      tx_data    <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      ovr        <= 1'b0;
      idx        <= '0;
      for (int i = 0; i < NUM_CH; i++) snap[i] <= '0;
    end else begin
      trmt       <= load;
      frame_done <= finish;
      ovr        <= tick && (state != S_IDLE);
      if (load) tx_data <= cur_byte;
      if (start) begin
        busy <= 1'b1;
        for (int i = 0; i < NUM_CH; i++) snap[i] <= ch_data[i*CH_W +: CH_W];
      end else if (finish) begin
        busy <= 1'b0;
      end
      if (finish)       idx <= '0;
      else if (advance) idx <= idx + IDX_W'(1);
    end
  end

`ifdef TELEM_CHKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     sum <= 8'h00;
    else if (start)                                 sum <= 8'h00;
    else if (load && idx >= IDX_W'(2) && !last)     sum <= sum + cur_byte;
  end
`endif

endmodule

// File: tb/tb_telemetry_pkt.sv
// Self-checking bench for telemetry_pkt: event-level frame model plus a UART responder with adjustable latency.
module tb_telemetry_pkt;

  localparam int PERIOD = 1000;
`ifdef TELEM_CHKSUM_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  localparam logic [35:0] DATA1 = {12'hFFF, 12'h123, 12'hABC};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [35:0] ch_data = '0;
  logic        tx_done = 1'b0;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        busy;
  logic        frame_done;
  logic        ovr;

  int tests_run = 0;
  int tests_failed = 0;
  int uart_lat = 20;
  longint cyc_count = 0;
  int trmt_count = 0;
  int fd_count = 0;
  int ovr_count = 0;
  logic [7:0] sent_q[$];
  longint     sent_cyc[$];

  telemetry_pkt #(.NUM_CH(3), .CH_W(12), .PERIOD(PERIOD), .DELIM(16'hAA55)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ch_data(ch_data), .tx_done(tx_done),
    .trmt(trmt), .tx_data(tx_data), .busy(busy), .frame_done(frame_done), .ovr(ovr)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc_count++;
  end

  task automatic checkOutput(input string name, input longint act, input longint exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      if (tests_failed <= 50)
        $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc_count, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [35:0] d);
    en      = e;
    ch_data = d;
  endtask

  // UART stand-in: one tx_done pulse uart_lat clocks after each trmt
  initial forever begin
    @(negedge clk);
    if (trmt && rst_n) begin
      automatic int lat = uart_lat;
      repeat (lat) @(posedge clk);
      #1 tx_done = 1'b1;
      @(posedge clk);
      #1 tx_done = 1'b0;
    end
  end

  // Frame model: expected bytes per accepted tick and the cycle each output event is due
  logic [7:0] exp_q[$];
  logic [7:0] exp_txd = 8'h00;
  logic       exp_busy = 1'b0;
  logic       waiting = 1'b0;
  longint     run = 0;
  longint     trmt_at = -1;
  longint     fd_at = -1;
  longint     ovr_at = -1;

  task automatic buildFrame(input logic [35:0] d);
    int v;
    logic [7:0] s;
    exp_q.delete();
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
    s = 8'h00;
    for (int i = 0; i < 3; i++) begin
      v = int'(d[i*12 +: 12]);
      exp_q.push_back(8'(v / 256));
      exp_q.push_back(8'(v % 256));
      s = s + 8'(v / 256) + 8'(v % 256);
    end
`ifdef TELEM_CHKSUM_EN
    exp_q.push_back(8'(256 - int'(s)));
`endif
  endtask

  always @(negedge clk) begin
    longint c;
    logic   tk;
    logic   cur_busy;
    c = cyc_count;
    if (!rst_n) begin
      checkOutput("rst_trmt", trmt, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_tx_data", tx_data, 0);
      checkOutput("rst_frame_done", frame_done, 0);
      checkOutput("rst_ovr", ovr, 0);
      run = 0; exp_busy = 0; waiting = 0; exp_txd = 8'h00;
      trmt_at = -1; fd_at = -1; ovr_at = -1;
      exp_q.delete();
    end else begin
      run = en ? run + 1 : 0;
      tk  = en && (run % PERIOD == 0);
      if (c == trmt_at) begin
        if (exp_q.size() == 0) checkOutput("byte_underflow", 1, 0);
        else exp_txd = exp_q.pop_front();
        waiting = 1'b1;
      end
      checkOutput("trmt", trmt, longint'(c == trmt_at));
      checkOutput("tx_data", tx_data, exp_txd);
      checkOutput("busy", busy, exp_busy);
      checkOutput("frame_done", frame_done, longint'(c == fd_at));
      checkOutput("ovr", ovr, longint'(c == ovr_at));
      if (trmt) begin
        sent_q.push_back(tx_data);
        sent_cyc.push_back(c);
        trmt_count++;
      end
      if (frame_done) fd_count++;
      if (ovr) ovr_count++;
      cur_busy = exp_busy;
      if (tx_done && waiting) begin
        waiting = 1'b0;
        if (exp_q.size() == 0) begin
          exp_busy = 1'b0;
          fd_at    = c + 1;
        end else begin
          trmt_at  = c + 2;
        end
      end
      if (tk) begin
        if (cur_busy) ovr_at = c + 1;
        else begin
          buildFrame(ch_data);
          exp_busy = 1'b1;
          trmt_at  = c + 2;
        end
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitFrameDone(input int budget, input string name);
    int start = fd_count;
    int k = 0;
    while (fd_count == start && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    checkOutput({name, "_frame_done_seen"}, longint'(fd_count > start), 1);
  endtask

  task automatic waitTrmts(input int n, input int budget, input string name);
    int start = trmt_count;
    int k = 0;
    while (trmt_count < start + n && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    checkOutput({name, "_trmt_seen"}, longint'(trmt_count >= start + n), 1);
  endtask

  task automatic waitBusy(input logic level, input int budget, input string name);
    int k = 0;
    while (busy != level && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    checkOutput({name, "_busy_level"}, busy, level);
  endtask

  initial begin
    logic [7:0] lit1[$];
    longint r;
    int tc, o0, fd0;
    lit1 = '{8'hAA, 8'h55, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h0F, 8'hFF};
`ifdef TELEM_CHKSUM_EN
    // payload 0A+BC+01+23+0F+FF = F8, so the closing byte is 08
    lit1.push_back(8'h08);
`endif

    applyStimulus(1'b0, '0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_trmt", trmt, 0);
    checkOutput("reset_tx_data", tx_data, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_frame_done", frame_done, 0);
    checkOutput("reset_ovr", ovr, 0);

    // Test 1: basic frame content and frame-to-frame spacing
    rst_n = 1'b1;
    applyStimulus(1'b1, DATA1);
    r = cyc_count;
    sent_q.delete();
    sent_cyc.delete();
    waitFrameDone(1300, "t1");
    checkOutput("t1_byte_count", sent_q.size(), NB);
    for (int k = 0; k < NB; k++)
      if (k < sent_q.size()) checkOutput($sformatf("t1_byte%0d", k), sent_q[k], lit1[k]);
    checkOutput("t1_first_trmt_cycle", sent_cyc.size() > 0 ? sent_cyc[0] - r : -1, 1001);
    checkOutput("t1_frame_done_count", fd_count, 1);
    waitTrmts(1, 1200, "t1_f2");
    checkOutput("t1_period", sent_cyc.size() > NB ? sent_cyc[NB] - sent_cyc[0] : -1, PERIOD);
    waitFrameDone(400, "t1_f2");

    // Test 2: inputs scrambled every cycle across the tick and the whole next frame
    fd0 = fd_count;
    for (int k = 0; k < 1400 && fd_count == fd0; k++) begin
      @(posedge clk);
      #1 ch_data = 36'({$urandom(), $urandom()});
    end
    checkOutput("t2_frame_done_seen", longint'(fd_count > fd0), 1);
    ch_data = DATA1;

    // Test 3: slow UART so frames outlast the period, forcing overruns
    o0 = ovr_count;
    uart_lat = 150;
    waitCycles(3000);
    checkOutput("t3_ovr_seen", longint'(ovr_count > o0), 1);
    uart_lat = 20;
    waitBusy(1'b0, 2000, "t3_drain");

    // Test 4: en dropped mid-frame, frame completes, nothing more until en returns
    waitBusy(1'b1, 1200, "t4_start");
    waitCycles(30);
    en = 1'b0;
    waitFrameDone(400, "t4");
    tc = trmt_count;
    waitCycles(2500);
    checkOutput("t4_no_trmt_while_disabled", trmt_count, tc);
    en = 1'b1;
    r = cyc_count;
    waitTrmts(1, 1100, "t4_reenable");
    checkOutput("t4_reenable_latency", sent_cyc[$] - r, 1001);
    checkOutput("t4_reenable_byte", sent_q[$], 8'hAA);
    waitFrameDone(400, "t4_after");

    // Test 5: reset while byte 4 is in flight
    tc = trmt_count;
    waitTrmts(4, 1200, "t5_pre");
    waitCycles(5);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t5_async_trmt", trmt, 0);
    checkOutput("t5_async_busy", busy, 0);
    checkOutput("t5_async_tx_data", tx_data, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    r = cyc_count;
    tc = trmt_count;
    waitTrmts(1, 1100, "t5_restart");
    checkOutput("t5_restart_latency", sent_cyc[$] - r, 1001);
    checkOutput("t5_restart_byte", sent_q[$], 8'hAA);
    waitFrameDone(400, "t5_after");
    checkOutput("t5_frame_bytes", trmt_count - tc, NB);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
